// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_operand_stage
//  Description : ID/EX pipeline register with EX-stage operand forwarding and
//                load-use bubble insertion, feeding the ALU directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_AW      = 5,
    parameter int OP_WIDTH    = 4,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   id_valid,
    input  logic [OP_WIDTH-1:0]    id_ALUOperation,
    input  logic [DATA_WIDTH-1:0]  id_rs_data,
    input  logic [DATA_WIDTH-1:0]  id_rt_data,
    input  logic [DATA_WIDTH-1:0]  id_imm,
    input  logic                   id_alu_src,
    input  logic [SHAMT_WIDTH-1:0] id_shamt,
    input  logic [REG_AW-1:0]      id_rs_addr,
    input  logic [REG_AW-1:0]      id_rt_addr,
    input  logic [REG_AW-1:0]      id_rd_addr,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,

    input  logic                   stall,
    input  logic                   flush,

    input  logic                   exmem_reg_write,
    input  logic [REG_AW-1:0]      exmem_rd_addr,
    input  logic [DATA_WIDTH-1:0]  exmem_result,
    input  logic                   memwb_reg_write,
    input  logic [REG_AW-1:0]      memwb_rd_addr,
    input  logic [DATA_WIDTH-1:0]  memwb_result,

    output logic                   ex_valid,
    output logic [OP_WIDTH-1:0]    ALUOperation,
    output logic [DATA_WIDTH-1:0]  A,
    output logic [DATA_WIDTH-1:0]  B,
    output logic [SHAMT_WIDTH-1:0] shamt,
    output logic [DATA_WIDTH-1:0]  ex_store_data,
    output logic [REG_AW-1:0]      ex_rd_addr,
    output logic                   ex_reg_write,
    output logic                   ex_mem_read,
    output logic                   load_use_hazard
);

    typedef struct packed {
        logic                   valid;
        logic [OP_WIDTH-1:0]    op;
        logic [DATA_WIDTH-1:0]  rs_data;
        logic [DATA_WIDTH-1:0]  rt_data;
        logic [DATA_WIDTH-1:0]  imm;
        logic                   alu_src;
        logic [SHAMT_WIDTH-1:0] shamt;
        logic [REG_AW-1:0]      rs_addr;
        logic [REG_AW-1:0]      rt_addr;
        logic [REG_AW-1:0]      rd_addr;
        logic                   reg_write;
        logic                   mem_read;
    } stage_t;

    stage_t stage_q;
    stage_t stage_d;

    // Youngest producer first; $0 is never a forwarding target.
    function automatic logic [DATA_WIDTH-1:0] fwd(
        input logic [REG_AW-1:0]     addr,
        input logic [DATA_WIDTH-1:0] data
    );
        if (addr == '0)
            return '0;
        else if (exmem_reg_write && (exmem_rd_addr == addr))
            return exmem_result;
        else if (memwb_reg_write && (memwb_rd_addr == addr))
            return memwb_result;
        else
            return data;
    endfunction

    logic w_rs_match;
    logic w_rt_match;

    always_comb begin
        w_rs_match      = (id_rs_addr == stage_q.rd_addr);
        w_rt_match      = (id_rt_addr == stage_q.rd_addr) && !id_alu_src;
        load_use_hazard = id_valid && stage_q.valid && stage_q.mem_read &&
                          (stage_q.rd_addr != '0) && (w_rs_match || w_rt_match);
    end

    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (stall) begin
            stage_d = stage_q;
        end else if (load_use_hazard) begin
            stage_d = '0;
        end else begin
            stage_d.valid     = id_valid;
            stage_d.op        = id_ALUOperation;
            stage_d.rs_data   = id_rs_data;
            stage_d.rt_data   = id_rt_data;
            stage_d.imm       = id_imm;
            stage_d.alu_src   = id_alu_src;
            stage_d.shamt     = id_shamt;
            stage_d.rs_addr   = id_rs_addr;
            stage_d.rt_addr   = id_rt_addr;
            stage_d.rd_addr   = id_rd_addr;
            stage_d.reg_write = id_reg_write && id_valid;
            stage_d.mem_read  = id_mem_read && id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            stage_q <= '0;
        else
            stage_q <= stage_d;
    end

    // Forwarding is re-evaluated every cycle, so a held stage still sees new producers.
    logic [DATA_WIDTH-1:0] w_rt_fwd;

    always_comb begin
        w_rt_fwd      = fwd(stage_q.rt_addr, stage_q.rt_data);
        A             = fwd(stage_q.rs_addr, stage_q.rs_data);
        B             = stage_q.alu_src ? stage_q.imm : w_rt_fwd;
        ex_store_data = w_rt_fwd;
    end

    assign ex_valid     = stage_q.valid;
    assign ALUOperation = stage_q.op;
    assign shamt        = stage_q.shamt;
    assign ex_rd_addr   = stage_q.rd_addr;
    assign ex_reg_write = stage_q.reg_write;
    assign ex_mem_read  = stage_q.mem_read;

endmodule
`default_nettype wire
